// File: rtl/kernel_if_pkg.sv
// Shared definitions for the host-side kernel job driver: FSM encoding, default
// operand geometry and a helper for building packed operand vectors.
package kernel_if_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ARM  = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } state_e;

    localparam int NARG_DEF    = 7;
    localparam int ARG_W_DEF   = 13;
    localparam int RES_W_DEF   = 13;
    localparam int TMO_W_DEF   = 8;
    localparam int TMO_MAX_DEF = 255;

    // Returns vec with operand slot idx replaced by val (slot 0 = init_a).
    function automatic logic [NARG_DEF*ARG_W_DEF-1:0] set_slot(
        input logic [NARG_DEF*ARG_W_DEF-1:0] vec,
        input int unsigned                   idx,
        input logic [ARG_W_DEF-1:0]          val
    );
        logic [NARG_DEF*ARG_W_DEF-1:0] r;
        r = vec;
        r[idx*ARG_W_DEF +: ARG_W_DEF] = val;
        return r;
    endfunction

endpackage

// File: rtl/kernel_job_driver.sv
// Drives one generated kernel through its r_enable/w_enable load/return handshake:
// accepts an operand job, pulses r_enable, waits for done or timeout, returns the result.
module kernel_job_driver
    import kernel_if_pkg::*;
#(
    parameter int NARG    = NARG_DEF,
    parameter int ARG_W   = ARG_W_DEF,
    parameter int RES_W   = RES_W_DEF,
    parameter int TMO_W   = TMO_W_DEF,
    parameter int TMO_MAX = TMO_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [NARG*ARG_W-1:0] s_args,
    output logic                  k_r_enable,
    output logic [NARG*ARG_W-1:0] k_init,
    input  logic                  k_w_enable,
    input  logic [RES_W-1:0]      k_result,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [RES_W-1:0]      m_result,
    output logic                  m_err,
    output logic [TMO_W-1:0]      last_lat,
    output logic                  busy
);

    state_e                  state_q, state_d;
    logic                    s_ready_q, s_ready_d;
    logic                    k_r_enable_q, k_r_enable_d;
    logic [NARG*ARG_W-1:0]   k_init_q, k_init_d;
    logic                    m_valid_q, m_valid_d;
    logic [RES_W-1:0]        m_result_q, m_result_d;
    logic                    m_err_q, m_err_d;
    logic [TMO_W-1:0]        last_lat_q, last_lat_d;
    logic                    busy_q, busy_d;
    logic [TMO_W-1:0]        cnt_q, cnt_d;

    // Latency is the WAIT count plus the LOAD and ARM cycles; clamped so it cannot wrap.
    logic [TMO_W:0]          lat_sum;
    logic [TMO_W-1:0]        lat_val;
    assign lat_sum = {1'b0, cnt_q} + (TMO_W+1)'(2);
    assign lat_val = lat_sum[TMO_W] ? '1 : lat_sum[TMO_W-1:0];

    always_comb begin
        state_d    = state_q;
        k_init_d   = k_init_q;
        m_result_d = m_result_q;
        m_err_d    = m_err_q;
        last_lat_d = last_lat_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: begin
                if (s_valid && s_ready_q) begin
                    k_init_d = s_args;
                    state_d  = LOAD;
                end
            end
            LOAD: state_d = ARM;
            // k_w_enable may still be high from the previous job here, so it is not looked at.
            ARM: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                if (k_w_enable) begin
                    m_result_d = k_result;
                    m_err_d    = 1'b0;
                    last_lat_d = lat_val;
                    state_d    = RESP;
                end else if (cnt_q == TMO_W'(TMO_MAX)) begin
                    m_result_d = '0;
                    m_err_d    = 1'b1;
                    last_lat_d = lat_val;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (m_valid_q && m_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        s_ready_d    = (state_d == IDLE);
        k_r_enable_d = (state_d == LOAD);
        m_valid_d    = (state_d == RESP);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            s_ready_q    <= 1'b0;
            k_r_enable_q <= 1'b0;
            k_init_q     <= '0;
            m_valid_q    <= 1'b0;
            m_result_q   <= '0;
            m_err_q      <= 1'b0;
            last_lat_q   <= '0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            s_ready_q    <= s_ready_d;
            k_r_enable_q <= k_r_enable_d;
            k_init_q     <= k_init_d;
            m_valid_q    <= m_valid_d;
            m_result_q   <= m_result_d;
            m_err_q      <= m_err_d;
            last_lat_q   <= last_lat_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign k_r_enable = k_r_enable_q;
    assign k_init     = k_init_q;
    assign m_valid    = m_valid_q;
    assign m_result   = m_result_q;
    assign m_err      = m_err_q;
    assign last_lat   = last_lat_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_kernel_job_driver.sv
// Self-checking bench for kernel_job_driver with a 7-input add kernel stub (latency 8,
// done held until one cycle after the next r_enable) and a short timeout.
module tb_kernel_job_driver;
    import kernel_if_pkg::*;

    localparam int NARG    = 7;
    localparam int ARG_W   = 13;
    localparam int RES_W   = 13;
    localparam int TMO_W   = 8;
    localparam int TMO_MAX = 15;
    localparam int KLAT    = 8;
    localparam int VW      = NARG*ARG_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [VW-1:0]     s_args = '0;
    logic              k_r_enable;
    logic [VW-1:0]     k_init;
    logic              k_w_enable;
    logic [RES_W-1:0]  k_result;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [RES_W-1:0]  m_result;
    logic              m_err;
    logic [TMO_W-1:0]  last_lat;
    logic              busy;

    kernel_job_driver #(
        .NARG(NARG), .ARG_W(ARG_W), .RES_W(RES_W), .TMO_W(TMO_W), .TMO_MAX(TMO_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_args(s_args),
        .k_r_enable(k_r_enable), .k_init(k_init),
        .k_w_enable(k_w_enable), .k_result(k_result),
        .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result),
        .m_err(m_err), .last_lat(last_lat), .busy(busy)
    );

    always #5 clk = ~clk;

    // Kernel stub: sums init operands; done is a level that lingers into the next ARM cycle.
    logic             kern_hang = 1'b0;
    logic             pu_phase  = 1'b1;
    logic             k_w = 1'b0;
    logic [RES_W-1:0] k_res = '0;
    logic             r_en_d1 = 1'b0;
    int               kcnt = 0;

    function automatic logic [RES_W-1:0] add_slots(input logic [VW-1:0] v);
        logic [RES_W-1:0] s;
        s = '0;
        for (int i = 0; i < NARG; i++) s = s + RES_W'(v[i*ARG_W +: ARG_W]);
        return s;
    endfunction

    always @(posedge clk) begin
        r_en_d1 <= k_r_enable;
        if (k_r_enable) kcnt <= 1;
        else if (kcnt != 0) begin
            if (kcnt == KLAT-1) begin
                kcnt <= 0;
                if (!kern_hang) begin
                    k_w   <= 1'b1;
                    k_res <= add_slots(k_init);
                end
            end else kcnt <= kcnt + 1;
        end
        if (r_en_d1) k_w <= 1'b0;
    end

    // Before the first job the kernel is unreset; model its garbage as a stale-high done.
    assign k_w_enable = pu_phase ? 1'b1 : k_w;
    assign k_result   = pu_phase ? '1   : k_res;

    int n_vec = 0;
    int n_err = 0;
    int re_pulses = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [RES_W-1:0] res;
        logic             err;
        logic [TMO_W-1:0] lat;
        string            name;
    } exp_t;
    exp_t sb_q[$];

    always @(negedge clk) begin
        if (k_r_enable) re_pulses++;
        if (rst_n && m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_response", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("resp %s: result=%0d err=%0b lat=%0d", e.name, m_result, m_err, last_lat);
                chk({e.name, "_result"}, 128'(m_result), 128'(e.res));
                chk({e.name, "_err"},    128'(m_err),    128'(e.err));
                chk({e.name, "_lat"},    128'(last_lat), 128'(e.lat));
            end
        end
    end

    function automatic logic [VW-1:0] pack7(input int a0, input int a1, input int a2,
                                            input int a3, input int a4, input int a5,
                                            input int a6);
        logic [VW-1:0] v;
        v = '0;
        v = set_slot(v, 0, ARG_W'(a0)); v = set_slot(v, 1, ARG_W'(a1));
        v = set_slot(v, 2, ARG_W'(a2)); v = set_slot(v, 3, ARG_W'(a3));
        v = set_slot(v, 4, ARG_W'(a4)); v = set_slot(v, 5, ARG_W'(a5));
        v = set_slot(v, 6, ARG_W'(a6));
        return v;
    endfunction

    task automatic submit(input logic [VW-1:0] args, input logic hang, input logic push,
                          input logic [RES_W-1:0] er, input logic ee,
                          input logic [TMO_W-1:0] el, input string name);
        bit got;
        kern_hang = hang;
        if (push) sb_q.push_back('{er, ee, el, name});
        s_args  = args;
        s_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (s_ready) got = 1;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        if (!got) chk({name, "_accept_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic wait_done(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            if (sb_q.size() == 0) done = 1;
        end
        if (!done) begin
            chk({name, "_response_timeout"}, 1'b0, 1'b1);
            sb_q.delete();
        end
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_s_ready"},  128'(s_ready),    128'(0));
        chk({tag, "_r_enable"}, 128'(k_r_enable), 128'(0));
        chk({tag, "_k_init"},   128'(k_init),     128'(0));
        chk({tag, "_m_valid"},  128'(m_valid),    128'(0));
        chk({tag, "_m_result"}, 128'(m_result),   128'(0));
        chk({tag, "_m_err"},    128'(m_err),      128'(0));
        chk({tag, "_last_lat"}, 128'(last_lat),   128'(0));
        chk({tag, "_busy"},     128'(busy),       128'(0));
    endtask

    typedef struct {
        logic [VW-1:0]    args;
        logic             hang;
        logic [RES_W-1:0] res;
        logic             err;
        logic [TMO_W-1:0] lat;
        string            name;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   p0;

        vecs[0] = '{pack7(1,2,3,4,5,6,7),        1'b0, 13'd28,  1'b0, 8'd8,  "single"};
        vecs[1] = '{pack7(10,20,30,40,50,60,70), 1'b0, 13'd280, 1'b0, 8'd8,  "b2b_a"};
        vecs[2] = '{pack7(0,0,0,0,0,0,0),        1'b0, 13'd0,   1'b0, 8'd8,  "b2b_zero"};
        vecs[3] = '{pack7(5,5,5,5,5,5,5),        1'b1, 13'd0,   1'b1, 8'd17, "timeout"};
        vecs[4] = '{pack7(2,4,6,8,10,12,14),     1'b0, 13'd56,  1'b0, 8'd8,  "after_tmo"};

        // Reset state, then power-up with a stale-high done before any job.
        #3;
        chk_reset_outs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("powerup_m_valid", 128'(m_valid), 128'(0));
            chk("powerup_no_x", 128'($isunknown({s_ready, k_r_enable, k_init, m_valid,
                                                m_result, m_err, last_lat, busy})), 128'(0));
        end
        chk("powerup_s_ready", 128'(s_ready), 128'(1));
        @(posedge clk); #1;
        pu_phase = 1'b0;

        // Table-driven jobs, m_ready tied high.
        for (int v = 0; v < 5; v++) begin
            p0 = re_pulses;
            submit(vecs[v].args, vecs[v].hang, 1'b1, vecs[v].res, vecs[v].err,
                   vecs[v].lat, vecs[v].name);
            wait_done(vecs[v].name);
            chk({vecs[v].name, "_r_pulses"}, 128'(re_pulses - p0), 128'(1));
            chk({vecs[v].name, "_k_init"},   128'(k_init), 128'(vecs[v].args));
        end

        // Back-pressure: response must hold for 20 cycles with m_ready low.
        begin
            bit seen;
            m_ready = 1'b0;
            p0 = re_pulses;
            submit(pack7(1,2,3,4,5,6,7), 1'b0, 1'b1, 13'd28, 1'b0, 8'd8, "bp");
            seen = 0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                if (m_valid) seen = 1;
            end
            chk("bp_m_valid_seen", 128'(seen), 128'(1));
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                chk("bp_m_valid",  128'(m_valid),  128'(1));
                chk("bp_m_result", 128'(m_result), 128'(28));
                chk("bp_m_err",    128'(m_err),    128'(0));
                chk("bp_s_ready",  128'(s_ready),  128'(0));
            end
            chk("bp_r_pulses_held", 128'(re_pulses - p0), 128'(1));
            @(posedge clk); #1;
            m_ready = 1'b1;
            wait_done("bp");
            chk("bp_r_pulses", 128'(re_pulses - p0), 128'(1));
        end

        // Reset three cycles after LOAD; outputs clear without waiting for a clock edge.
        begin
            bit seen;
            submit(pack7(3,3,3,3,3,3,3), 1'b0, 1'b0, 13'd0, 1'b0, 8'd0, "abort");
            seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (k_r_enable) seen = 1;
            end
            chk("abort_load_seen", 128'(seen), 128'(1));
            repeat (3) @(posedge clk);
            #3 rst_n = 1'b0;
            #1;
            chk_reset_outs("midwait_reset");
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            p0 = re_pulses;
            submit(pack7(1,1,1,1,1,1,1), 1'b0, 1'b1, 13'd7, 1'b0, 8'd8, "post_reset");
            wait_done("post_reset");
            chk("post_reset_r_pulses", 128'(re_pulses - p0), 128'(1));
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang, expected finish");
        $fatal(1, "global timeout");
    end

endmodule
